pvz_bg_scroll_renderer: RTL
===========================

// Module: pvz_bg_scroll_renderer
// PURPOSE
//  Parametrised background sprite renderer with scaling and horizontal scroll.
//  Maps screen pixel (DrawX,DrawY) onto an SRC_W x SRC_H indexed sprite ROM, scaled to
//  SCR_W x SCR_H using incremental (Bresenham) steppers instead of divides or multiplies.
//  Adds a frame-synchronous wrap-around scroll. Sits between the VGA timing generator,
//  the external sprite ROM/palette and the pixel mux.
// PARAMETERS
//  SRC_W   640  sprite width in texels
//  SRC_H   240  sprite height in texels
//  SCR_W   640  visible screen width; SRC_W <= SCR_W
//  SCR_H   480  visible screen height; SRC_H <= SCR_H
//  ADDR_W  18   ROM address width; must satisfy 2**ADDR_W >= SRC_W*SRC_H
//  IDX_W   4    palette index width
//  ROM_LAT 1    ROM read latency in vga_clk cycles (>=1)
// PORTS
//  vga_clk     in   1       pixel clock, all logic on posedge
//  reset_n     in   1       asynchronous active-low reset
//  DrawX       in   10      current pixel column
//  DrawY       in   10      current pixel row
//  blank       in   1       1 = visible pixel (display enable)
//  scroll_x    in   10      requested horizontal texel offset
//  scroll_load in   1       1-cycle strobe: capture scroll_x into shadow register
//  rom_addr    out  ADDR_W  sprite ROM address (registered)
//  rom_q       in   IDX_W   ROM data, valid ROM_LAT cycles after rom_addr
//  pix_index   out  IDX_W   registered palette index to external palette
//  pal_r/g/b   in   4 each  combinational palette colour for pix_index
//  red/green/blue out 4 each final registered colour
// BEHAVIOUR
//  - Reset: rom_addr, pix_index, red/green/blue = 0; shadow & active scroll = 0;
//    all steppers, row_base and blank delay line cleared.
//  - scroll_load: shadow <= min(scroll_x, SRC_W-1). Shadow -> active scroll only at
//    frame start (DrawX==0 && DrawY==0); mid-frame loads never alter the current frame.
//    scroll_load coincident with frame start: new value is used that same frame.
//  - Column stepper: at DrawX==0 src_x <= active scroll, xacc <= 0. Each cycle with
//    DrawX<SCR_W: xacc += SRC_W; if result >= SCR_W subtract SCR_W and advance src_x;
//    src_x wraps SRC_W-1 -> 0.
//  - Row stepper: at DrawY==0 (DrawX==0) src_y, yacc, row_base <= 0. At DrawX==SCR_W
//    (end of visible line): yacc += SRC_H; on overflow subtract SCR_H, src_y++ and
//    row_base += SRC_W. src_y saturates at SRC_H-1 (never wraps vertically).
//  - rom_addr <= row_base + src_x, registered: pixel (X,Y) address valid 1 cycle later.
//  - pix_index <= rom_q one cycle after ROM data valid; red/green/blue <= pal_* one
//    cycle later. Total DrawX -> RGB latency = ROM_LAT+3 cycles.
//  - blank delayed by identical pipeline depth; RGB = 0 when delayed blank is 0.
//  - Steppers advance only on DrawX/DrawY conditions above, independent of blank.
//  - reset_n asserted mid-frame: immediate clear; resumes correctly from next DrawX==0.
// CONFIGURATION
//  PVZ_BG_TRANSPARENT_EN defined: adds parameter KEY_IDX (default 0) and output
//   port opaque (1 bit, registered, aligned with red/green/blue); opaque = 0 and
//   RGB = 0 when the pixel's index == KEY_IDX or delayed blank is 0, else opaque = 1.
//  Not defined: no opaque port, no KEY_IDX; every index is drawn through the palette.
// TESTING
//  Reset: hold reset_n=0 with blank=1 -> all outputs 0, rom_addr 0.
//  Default params, scroll 0: DrawY=0,1 -> rows share row_base 0; DrawY=2,X=5 -> rom_addr 645.
//  Identity SRC_W=SCR_W=640, SRC_H=SCR_H=480: (X=3,Y=2) -> rom_addr 1283 one cycle later.
//  Scroll 100: DrawX=0 -> addr 100; DrawX=539 -> 639; DrawX=540 -> 0 (wrap).
//  scroll_load 200 at Y=100 -> rest of frame uses old scroll; next frame DrawX=0 -> 200.
//  scroll_x=700 -> clamped 639. blank pulse: RGB follows ROM_LAT+3 cycles later, else 0.
//  PVZ_BG_TRANSPARENT_EN, rom_q=0 -> opaque=0, RGB=0; rom_q=5 -> opaque=1, RGB=pal.

Source files
------------

// File: rtl/pvz_bg_scroll_renderer.sv
// Scaled, horizontally wrap-scrolling background sprite renderer driven by VGA raster position.
// Define PVZ_BG_TRANSPARENT_EN to add colour-key transparency (KEY_IDX parameter, opaque output).
module pvz_bg_scroll_renderer #(
    parameter int SRC_W   = 640,
    parameter int SRC_H   = 240,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int ADDR_W  = 18,
    parameter int IDX_W   = 4,
    parameter int ROM_LAT = 1
`ifdef PVZ_BG_TRANSPARENT_EN
    ,
    parameter int KEY_IDX = 0
`endif
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        scroll_x,
    input  logic              scroll_load,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_index,
    input  logic [3:0]        pal_r,
    input  logic [3:0]        pal_g,
    input  logic [3:0]        pal_b,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
`ifdef PVZ_BG_TRANSPARENT_EN
    ,
    output logic              opaque
`endif
);

    localparam int ACC_W   = 12;
    localparam int BLANK_D = ROM_LAT + 2;

    localparam logic [ACC_W-1:0]  SRC_W_ACC  = ACC_W'(SRC_W);
    localparam logic [ACC_W-1:0]  SCR_W_ACC  = ACC_W'(SCR_W);
    localparam logic [ACC_W-1:0]  SRC_H_ACC  = ACC_W'(SRC_H);
    localparam logic [ACC_W-1:0]  SCR_H_ACC  = ACC_W'(SCR_H);
    localparam logic [9:0]        SCR_W_POS  = 10'(SCR_W);
    localparam logic [9:0]        SRC_X_MAX  = 10'(SRC_W - 1);
    localparam logic [9:0]        SRC_Y_MAX  = 10'(SRC_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SRC_W);

    function automatic logic [9:0] clamp_scroll(input logic [9:0] v);
        return (v > SRC_X_MAX) ? SRC_X_MAX : v;
    endfunction

    logic [9:0]        shadow_scroll;
    logic [9:0]        active_scroll;
    logic [9:0]        src_x;
    logic [ACC_W-1:0]  xacc;
    logic [9:0]        src_y;
    logic [ACC_W-1:0]  yacc;
    logic [ADDR_W-1:0] row_base;
    logic [BLANK_D-1:0] blank_p;

    logic              frame_start;
    logic              line_start;
    logic              line_end;
    logic              in_line;
    logic [9:0]        scroll_now;
    logic [9:0]        cur_x;
    logic [ACC_W-1:0]  cur_xacc;
    logic [ADDR_W-1:0] cur_base;
    logic [ACC_W-1:0]  x_sum;
    logic              x_step;
    logic [9:0]        x_next;
    logic [ACC_W-1:0]  y_sum;
    logic              y_step;
    logic              blank_d;
    logic              draw;

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign line_start  = (DrawX == 10'd0);
    assign line_end    = (DrawX == SCR_W_POS);
    assign in_line     = (DrawX < SCR_W_POS);

    // A load coinciding with frame start bypasses the shadow so it takes effect this frame.
    assign scroll_now = frame_start ? (scroll_load ? clamp_scroll(scroll_x) : shadow_scroll)
                                    : active_scroll;

    // Line/frame restarts are resolved combinationally so pixel 0 of a line uses fresh state.
    assign cur_x    = line_start  ? scroll_now : src_x;
    assign cur_xacc = line_start  ? '0         : xacc;
    assign cur_base = frame_start ? '0         : row_base;

    assign x_sum  = cur_xacc + SRC_W_ACC;
    assign x_step = (x_sum >= SCR_W_ACC);
    assign x_next = (cur_x == SRC_X_MAX) ? 10'd0 : cur_x + 10'd1;

    assign y_sum  = yacc + SRC_H_ACC;
    assign y_step = (y_sum >= SCR_H_ACC);

    assign blank_d = blank_p[BLANK_D-1];

`ifdef PVZ_BG_TRANSPARENT_EN
    assign draw = blank_d && (pix_index != IDX_W'(KEY_IDX));
`else
    assign draw = blank_d;
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_scroll <= '0;
            active_scroll <= '0;
        end else begin
            if (scroll_load)
                shadow_scroll <= clamp_scroll(scroll_x);
            if (frame_start)
                active_scroll <= scroll_now;
        end
    end

    // Column stepper: Bresenham-style texel advance across the visible line.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            src_x <= '0;
            xacc  <= '0;
        end else if (in_line) begin
            if (x_step) begin
                xacc  <= x_sum - SCR_W_ACC;
                src_x <= x_next;
            end else begin
                xacc  <= x_sum;
                src_x <= cur_x;
            end
        end
    end

    // Row stepper: advances once per line end and saturates on the last sprite row.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            src_y    <= '0;
            yacc     <= '0;
            row_base <= '0;
        end else if (frame_start) begin
            src_y    <= '0;
            yacc     <= '0;
            row_base <= '0;
        end else if (line_end) begin
            if (y_step) begin
                yacc <= y_sum - SCR_H_ACC;
                if (src_y != SRC_Y_MAX) begin
                    src_y    <= src_y + 10'd1;
                    row_base <= row_base + ROW_STRIDE;
                end
            end else begin
                yacc <= y_sum;
            end
        end
    end

    // Stage 0: ROM address.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            rom_addr <= '0;
        else
            rom_addr <= cur_base + ADDR_W'(cur_x);
    end

    // Stage 1+ROM_LAT: palette index, with blank delayed to match.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_index <= '0;
            blank_p   <= '0;
        end else begin
            pix_index <= rom_q;
            blank_p   <= {blank_p[BLANK_D-2:0], blank};
        end
    end

    // Stage 2+ROM_LAT: final colour.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (draw) begin
            red   <= pal_r;
            green <= pal_g;
            blue  <= pal_b;
        end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end
    end

`ifdef PVZ_BG_TRANSPARENT_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            opaque <= 1'b0;
        else
            opaque <= draw;
    end
`endif

endmodule
